// File: rtl/dsp_mac_pkg.sv
// rtl/dsp_mac_pkg.sv - shared widths and opmode bit positions for the MAC stage
package dsp_mac_pkg;

  // Default operand and accumulator widths
  localparam int AW_DEF = 18;
  localparam int PW_DEF = 48;

  // Opmode bit positions
  localparam int OP_PRESUB  = 0;
  localparam int OP_PREBYP  = 1;
  localparam int OP_ACC     = 2;
  localparam int OP_POSTSUB = 3;

endpackage

// File: rtl/dsp_stage_reg.sv
// rtl/dsp_stage_reg.sv - clock-enabled pipeline register with async active-low clear
module dsp_stage_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Capture on enabled edges; reset clears immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (ce) begin
      q <= d;
    end
  end

endmodule

// File: rtl/dsp_mac_stage.sv
// rtl/dsp_mac_stage.sv - three-stage pre-add / multiply / post-add-accumulate pipeline
module dsp_mac_stage
  import dsp_mac_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int PW = PW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ce,
  input  logic            in_valid,
  input  logic [AW-1:0]   a,
  input  logic [AW-1:0]   b,
  input  logic [AW-1:0]   d,
  input  logic [PW-1:0]   c,
  input  logic [3:0]      opmode,
  input  logic            carry_in,
  output logic [2*AW-1:0] m,
  output logic [PW-1:0]   p,
  output logic            carry_out,
  output logic            out_valid
);

  // Stage 1 carries pre-adder result, A, C, post-sub, accumulate, carry-in, valid
  localparam int S1W = AW + AW + PW + 4;
  // Stage 2 carries product, C, post-sub, accumulate, carry-in, valid
  localparam int S2W = 2 * AW + PW + 4;

  logic [AW-1:0]   pre_nxt;
  logic [S1W-1:0]  s1_d;
  logic [S1W-1:0]  s1_q;
  logic [AW-1:0]   pre1;
  logic [AW-1:0]   a1;
  logic [PW-1:0]   c1;
  logic            sub1;
  logic            acc1;
  logic            cin1;
  logic            v1;

  logic signed [2*AW-1:0] prod;
  logic [S2W-1:0]  s2_d;
  logic [S2W-1:0]  s2_q;
  logic [PW-1:0]   c2;
  logic            sub2;
  logic            acc2;
  logic            cin2;
  logic            v2;

  logic [PW-1:0]   x_ext;
  logic [PW-1:0]   z_sel;
  logic [PW:0]     sum;
  logic [PW:0]     s3_q;
  logic            s3_ce;

  // Pre-adder: bypass passes B, otherwise D+B or D-B wrapped to AW bits
  always_comb begin
    pre_nxt = d + b;
    if (opmode[OP_PREBYP]) begin
      pre_nxt = b;
    end else if (opmode[OP_PRESUB]) begin
      pre_nxt = d - b;
    end
  end

  assign s1_d = {pre_nxt, a, c, opmode[OP_POSTSUB], opmode[OP_ACC], carry_in, in_valid};

  dsp_stage_reg #(.W(S1W)) u_stage1 (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .d     (s1_d),
    .q     (s1_q)
  );

  assign {pre1, a1, c1, sub1, acc1, cin1, v1} = s1_q;

  // Full-width signed product, no overflow possible at 2*AW bits
  assign prod = $signed(pre1) * $signed(a1);
  assign s2_d = {prod, c1, sub1, acc1, cin1, v1};

  // Stage 2 updates on every enabled edge, bubbles included
  dsp_stage_reg #(.W(S2W)) u_stage2 (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .d     (s2_d),
    .q     (s2_q)
  );

  assign {m, c2, sub2, acc2, cin2, v2} = s2_q;

  assign x_ext = {{(PW - 2 * AW){m[2*AW-1]}}, m};
  // Accumulate feeds back the live P register, so adjacent samples chain
  assign z_sel = acc2 ? p : c2;

  // Post-adder computed one bit wider so the top bit is carry or borrow
  always_comb begin
    sum = {1'b0, z_sel} + {1'b0, x_ext} + {{PW{1'b0}}, cin2};
    if (sub2) begin
      sum = {1'b0, z_sel} - ({1'b0, x_ext} + {{PW{1'b0}}, cin2});
    end
  end

  // Result register only loads live samples so bubbles leave P untouched
  assign s3_ce = ce & v2;

  dsp_stage_reg #(.W(PW + 1)) u_stage3 (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (s3_ce),
    .d     (sum),
    .q     (s3_q)
  );

  assign carry_out = s3_q[PW];
  assign p         = s3_q[PW-1:0];

  dsp_stage_reg #(.W(1)) u_valid3 (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .d     (v2),
    .q     (out_valid)
  );

endmodule

// File: tb/tb_dsp_mac_stage.sv
// tb/tb_dsp_mac_stage.sv - self-checking scoreboard bench for dsp_mac_stage
module tb_dsp_mac_stage;

  typedef struct {
    logic        v;
    logic        en;
    logic [17:0] a;
    logic [17:0] b;
    logic [17:0] d;
    logic [47:0] c;
    logic [3:0]  op;
    logic        cin;
  } stim_t;

  logic        clk;
  logic        rst_n;
  logic        ce;
  logic        in_valid;
  logic [17:0] a;
  logic [17:0] b;
  logic [17:0] d;
  logic [47:0] c;
  logic [3:0]  opmode;
  logic        carry_in;
  logic [35:0] m;
  logic [47:0] p;
  logic        carry_out;
  logic        out_valid;

  int          errors;
  int          checks;
  logic [48:0] sb[$];
  logic [48:0] last_pc;
  logic [35:0] exp_m;
  logic [35:0] exp_m1;
  logic [47:0] model_p;
  logic        last_ce;

  dsp_mac_stage #(.AW(18), .PW(48)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .d         (d),
    .c         (c),
    .opmode    (opmode),
    .carry_in  (carry_in),
    .m         (m),
    .p         (p),
    .carry_out (carry_out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mk(input logic v, input logic en, input logic [17:0] sa,
                               input logic [17:0] sb_, input logic [17:0] sd,
                               input logic [47:0] sc, input logic [3:0] op, input logic cin);
    stim_t s;
    s.v = v; s.en = en; s.a = sa; s.b = sb_; s.d = sd; s.c = sc; s.op = op; s.cin = cin;
    return s;
  endfunction

  function automatic stim_t bubble();
    return mk(1'b0, 1'b1, 18'd0, 18'd0, 18'd0, 48'd0, 4'd0, 1'b0);
  endfunction

  function automatic logic [35:0] model_prod(input stim_t s);
    logic [17:0]        pre;
    logic signed [35:0] r;
    if (s.op[1])      pre = s.b;
    else if (s.op[0]) pre = s.d - s.b;
    else              pre = s.d + s.b;
    r = $signed(pre) * $signed(s.a);
    return r;
  endfunction

  function automatic logic [48:0] model_post(input stim_t s, input logic [35:0] mm);
    logic [47:0] x;
    logic [47:0] z;
    x = {{12{mm[35]}}, mm};
    z = s.op[2] ? model_p : s.c;
    if (s.op[3]) return {1'b0, z} - ({1'b0, x} + {48'd0, s.cin});
    return {1'b0, z} + {1'b0, x} + {48'd0, s.cin};
  endfunction

  task automatic apply(input stim_t s);
    logic [48:0] r;
    in_valid = s.v; ce = s.en; a = s.a; b = s.b; d = s.d; c = s.c;
    opmode = s.op; carry_in = s.cin;
    if (s.en && s.v) begin
      r = model_post(s, model_prod(s));
      sb.push_back(r);
      model_p = r[47:0];
    end
    @(posedge clk);
    if (s.en) begin
      exp_m  = exp_m1;
      exp_m1 = model_prod(s);
    end
    last_ce = s.en;
    @(negedge clk);
  endtask

  task automatic clear_model();
    sb.delete();
    model_p = '0; last_pc = '0; exp_m = '0; exp_m1 = '0; last_ce = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; ce = 1'b1; a = '0; b = '0; d = '0; c = '0; opmode = '0; carry_in = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (p !== 48'd0) begin errors++; $display("FAIL reset_p got=%h need=0", p); end
    checks++; if (m !== 36'd0) begin errors++; $display("FAIL reset_m got=%h need=0", m); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL reset_carry got=%b need=0", carry_out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b need=0", out_valid); end
  endtask

  task automatic test_pre_paths();
    stim_t st[$];
    logic [48:0] e;
    int pulses;
    pulses = 0;
    st.push_back(mk(1'b1, 1'b1, 18'd4, 18'd3, 18'd10, 48'd100, 4'b0000, 1'b0));
    repeat (4) st.push_back(bubble());
    st.push_back(mk(1'b1, 1'b1, 18'd4, 18'd3, 18'd10, 48'd100, 4'b1001, 1'b0));
    st.push_back(mk(1'b1, 1'b1, 18'd6, 18'h3FFFB, 18'd7, 48'd0, 4'b0010, 1'b0));
    repeat (4) st.push_back(bubble());
    foreach (st[i]) begin
      apply(st[i]);
      if (i == 2) begin
        checks++; if (p !== 48'd152) begin errors++; $display("FAIL preadd_p got=%0d need=152", p); end
      end
      if (out_valid && last_ce) begin
        checks++;
        if (i < 5) pulses++;
        if (sb.size() == 0) begin errors++; $display("FAIL pre_stale got p=%h need no output", p); end
        else begin
          e = sb.pop_front();
          if ({carry_out, p} !== e) begin errors++; $display("FAIL pre_result got=%h need=%h", {carry_out, p}, e); end
          last_pc = e;
        end
      end else begin
        checks++; if ({carry_out, p} !== last_pc) begin errors++; $display("FAIL pre_hold got=%h need=%h", {carry_out, p}, last_pc); end
      end
      checks++; if (m !== exp_m) begin errors++; $display("FAIL pre_m got=%h need=%h", m, exp_m); end
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL preadd_pulses got=%0d need=1", pulses); end
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL pre_lost got=%0d pending need=0", sb.size()); end
  endtask

  task automatic test_accumulate();
    stim_t st[$];
    logic [48:0] e;
    stim_t s;
    do_reset();
    s = mk(1'b1, 1'b1, 18'd1, 18'd1, 18'd1, 48'd0, 4'b0100, 1'b0);
    st.push_back(s); st.push_back(s);
    st.push_back(bubble());
    st.push_back(s); st.push_back(s); st.push_back(s);
    repeat (4) st.push_back(bubble());
    foreach (st[i]) begin
      apply(st[i]);
      if (out_valid && last_ce) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL acc_stale got p=%h need no output", p); end
        else begin
          e = sb.pop_front();
          if ({carry_out, p} !== e) begin errors++; $display("FAIL acc_result got=%h need=%h", {carry_out, p}, e); end
          last_pc = e;
        end
      end else begin
        checks++; if ({carry_out, p} !== last_pc) begin errors++; $display("FAIL acc_hold got=%h need=%h", {carry_out, p}, last_pc); end
      end
      checks++; if (m !== exp_m) begin errors++; $display("FAIL acc_m got=%h need=%h", m, exp_m); end
    end
    checks++; if (p !== 48'd10) begin errors++; $display("FAIL acc_final got=%0d need=10", p); end
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL acc_lost got=%0d pending need=0", sb.size()); end
  endtask

  task automatic test_carry();
    stim_t st[$];
    logic [48:0] e;
    st.push_back(mk(1'b1, 1'b1, 18'd1, 18'd1, 18'd0, 48'hFFFF_FFFF_FFFF, 4'b0000, 1'b0));
    repeat (3) st.push_back(bubble());
    checks += 0;
    foreach (st[i]) begin
      apply(st[i]);
      if (out_valid && last_ce) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL carry_stale got p=%h need no output", p); end
        else begin
          e = sb.pop_front();
          if ({carry_out, p} !== e) begin errors++; $display("FAIL carry_result got=%h need=%h", {carry_out, p}, e); end
          last_pc = e;
        end
      end else begin
        checks++; if ({carry_out, p} !== last_pc) begin errors++; $display("FAIL carry_hold got=%h need=%h", {carry_out, p}, last_pc); end
      end
      checks++; if (m !== exp_m) begin errors++; $display("FAIL carry_m got=%h need=%h", m, exp_m); end
    end
    checks++; if ({carry_out, p} !== {1'b1, 48'd0}) begin errors++; $display("FAIL carry_a got=%h need=1000000000000", {carry_out, p}); end
    st.delete();
    st.push_back(mk(1'b1, 1'b1, 18'd0, 18'd1, 18'd0, 48'hFFFF_FFFF_FFFF, 4'b0000, 1'b1));
    repeat (3) st.push_back(bubble());
    foreach (st[i]) begin
      apply(st[i]);
      if (out_valid && last_ce) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL carry2_stale got p=%h need no output", p); end
        else begin
          e = sb.pop_front();
          if ({carry_out, p} !== e) begin errors++; $display("FAIL carry2_result got=%h need=%h", {carry_out, p}, e); end
          last_pc = e;
        end
      end
    end
    checks++; if ({carry_out, p} !== {1'b1, 48'd0}) begin errors++; $display("FAIL carry_b got=%h need=1000000000000", {carry_out, p}); end
  endtask

  task automatic test_stall();
    stim_t st[$];
    logic [48:0] e;
    int outs;
    outs = 0;
    st.push_back(mk(1'b1, 1'b1, 18'd3, 18'd2, 18'd5, 48'd1000, 4'b0000, 1'b0));
    st.push_back(mk(1'b1, 1'b1, 18'd7, 18'd1, 18'd9, 48'd50, 4'b1001, 1'b1));
    repeat (4) st.push_back(mk(1'b1, 1'b0, 18'h155, 18'h2AA, 18'h0F0, 48'hDEAD, 4'b0101, 1'b1));
    st.push_back(mk(1'b1, 1'b1, 18'd2, 18'd4, 18'd6, 48'd0, 4'b0100, 1'b0));
    repeat (4) st.push_back(bubble());
    foreach (st[i]) begin
      apply(st[i]);
      if (out_valid && last_ce) begin
        checks++;
        outs++;
        if (sb.size() == 0) begin errors++; $display("FAIL stall_stale got p=%h need no output", p); end
        else begin
          e = sb.pop_front();
          if ({carry_out, p} !== e) begin errors++; $display("FAIL stall_result got=%h need=%h", {carry_out, p}, e); end
          last_pc = e;
        end
      end else begin
        checks++; if ({carry_out, p} !== last_pc) begin errors++; $display("FAIL stall_hold got=%h need=%h", {carry_out, p}, last_pc); end
      end
      checks++; if (m !== exp_m) begin errors++; $display("FAIL stall_m got=%h need=%h", m, exp_m); end
    end
    checks++; if (outs !== 3) begin errors++; $display("FAIL stall_count got=%0d need=3", outs); end
  endtask

  task automatic test_back_to_back();
    stim_t st[$];
    stim_t s;
    logic [48:0] e;
    for (int k = 0; k < 40; k++) begin
      s.v   = ($urandom_range(3) != 0);
      s.en  = ($urandom_range(3) != 0);
      s.a   = 18'($urandom);
      s.b   = 18'($urandom);
      s.d   = 18'($urandom);
      s.c   = {16'($urandom), $urandom};
      s.op  = 4'($urandom);
      s.cin = 1'($urandom);
      st.push_back(s);
    end
    repeat (4) st.push_back(bubble());
    foreach (st[i]) begin
      apply(st[i]);
      if (out_valid && last_ce) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL b2b_stale got p=%h need no output", p); end
        else begin
          e = sb.pop_front();
          if ({carry_out, p} !== e) begin errors++; $display("FAIL b2b_result got=%h need=%h", {carry_out, p}, e); end
          last_pc = e;
        end
      end else begin
        checks++; if ({carry_out, p} !== last_pc) begin errors++; $display("FAIL b2b_hold got=%h need=%h", {carry_out, p}, last_pc); end
      end
      checks++; if (m !== exp_m) begin errors++; $display("FAIL b2b_m got=%h need=%h", m, exp_m); end
    end
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL b2b_lost got=%0d pending need=0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    stim_t st[$];
    logic [48:0] e;
    st.push_back(mk(1'b1, 1'b1, 18'd2, 18'd3, 18'd4, 48'd500, 4'b0000, 1'b1));
    st.push_back(mk(1'b1, 1'b1, 18'd5, 18'd1, 18'd1, 48'd10, 4'b0000, 1'b0));
    st.push_back(mk(1'b1, 1'b1, 18'd6, 18'd2, 18'd2, 48'd20, 4'b0100, 1'b0));
    foreach (st[i]) apply(st[i]);
    checks++; if (p !== 48'd515) begin errors++; $display("FAIL midrst_pre got=%0d need=515", p); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (p !== 48'd0) begin errors++; $display("FAIL midrst_p got=%h need=0", p); end
    checks++; if (m !== 36'd0) begin errors++; $display("FAIL midrst_m got=%h need=0", m); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL midrst_carry got=%b need=0", carry_out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b need=0", out_valid); end
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    st.delete();
    repeat (5) st.push_back(bubble());
    st.push_back(mk(1'b1, 1'b1, 18'd1, 18'd1, 18'd1, 48'd77, 4'b0100, 1'b0));
    repeat (4) st.push_back(bubble());
    foreach (st[i]) begin
      apply(st[i]);
      if (out_valid && last_ce) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL midrst_stale got p=%h need no output", p); end
        else begin
          e = sb.pop_front();
          if ({carry_out, p} !== e) begin errors++; $display("FAIL midrst_result got=%h need=%h", {carry_out, p}, e); end
          last_pc = e;
        end
      end else begin
        checks++; if ({carry_out, p} !== last_pc) begin errors++; $display("FAIL midrst_hold got=%h need=%h", {carry_out, p}, last_pc); end
      end
      checks++; if (m !== exp_m) begin errors++; $display("FAIL midrst_m_run got=%h need=%h", m, exp_m); end
    end
    checks++; if (p !== 48'd2) begin errors++; $display("FAIL midrst_acc got=%0d need=2", p); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_pre_paths();
    test_accumulate();
    test_carry();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
